// File: rtl/odd_even_sorter_if.sv
// Handshake bundle for odd_even_sorter.
// Build option: SORTER_EARLY_EXIT_EN (consumed by the sorter, not by this file).
// Ports (slave = sorter side):
//   in_valid/in_ready/in_data/in_desc     input vector channel, sort order
//   out_valid/out_ready/out_data/out_swaps sorted vector channel, swap count
//   busy                                  sorter is in SORT or DONE
interface odd_even_sorter_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned W      = 8,
    parameter int unsigned SWAP_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [N*W-1:0]    in_data;
    logic              in_desc;
    logic              out_valid;
    logic              out_ready;
    logic [N*W-1:0]    out_data;
    logic [SWAP_W-1:0] out_swaps;
    logic              busy;

    modport master (
        output in_valid, in_data, in_desc, out_ready,
        input  in_ready, out_valid, out_data, out_swaps, busy
    );

    modport slave (
        input  in_valid, in_data, in_desc, out_ready,
        output in_ready, out_valid, out_data, out_swaps, busy
    );
endinterface

// File: rtl/odd_even_sorter.sv
// N-element, W-bit unsigned sorter using odd-even transposition, one
// compare-exchange phase per clock, ascending or descending, with a
// saturating count of exchanges.
// Optional feature macro: SORTER_EARLY_EXIT_EN -- finish after two
// consecutive phases with no exchange instead of always running N phases.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         odd_even_sorter_if.slave handshake bundle
module odd_even_sorter #(
    parameter int unsigned N      = 8,
    parameter int unsigned W      = 8,
    parameter int unsigned SWAP_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    odd_even_sorter_if.slave bus
);
    localparam int unsigned VEC_W = N * W;
    localparam int unsigned PH_W  = $clog2(N);
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [SWAP_W-1:0]   swaps_q, swaps_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic                desc_q, desc_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
`ifdef SORTER_EARLY_EXIT_EN
    logic                quiet_q, quiet_d;   // previous phase made no exchange
`endif

    logic [VEC_W-1:0]    xchg_vec;
    logic [CNT_W-1:0]    xchg_cnt;
    logic [SWAP_W:0]     swaps_sum;
    logic [SWAP_W-1:0]   swaps_sat;

    // Single compare-exchange layer; pair (j,j+1) is active when j parity matches phase parity.
    always_comb begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        xchg_vec = vec_q;
        xchg_cnt = '0;
        for (int j = 0; j < int'(N) - 1; j++) begin
            a = vec_q[j*W +: W];
            b = vec_q[(j+1)*W +: W];
            if (1'(j) == phase_q[0]) begin
                if (desc_q ? (a < b) : (a > b)) begin
                    xchg_vec[j*W +: W]     = b;
                    xchg_vec[(j+1)*W +: W] = a;
                    xchg_cnt               = xchg_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Saturating accumulation of exchanges.
    always_comb begin
        swaps_sum = (SWAP_W+1)'(swaps_q) + (SWAP_W+1)'(xchg_cnt);
        swaps_sat = swaps_sum[SWAP_W] ? {SWAP_W{1'b1}} : swaps_sum[SWAP_W-1:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        swaps_d = swaps_q;
        phase_d = phase_q;
        desc_d  = desc_q;
`ifdef SORTER_EARLY_EXIT_EN
        quiet_d = quiet_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    vec_d   = bus.in_data;
                    desc_d  = bus.in_desc;
                    phase_d = '0;
                    swaps_d = '0;
`ifdef SORTER_EARLY_EXIT_EN
                    quiet_d = 1'b0;
`endif
                    state_d = SORT;
                end
            end
            SORT: begin
                vec_d   = xchg_vec;
                swaps_d = swaps_sat;
                phase_d = phase_q + PH_W'(1);
                if (phase_q == PH_W'(N - 1)) begin
                    state_d = DONE;
                end
`ifdef SORTER_EARLY_EXIT_EN
                quiet_d = (xchg_cnt == '0);
                if (quiet_q && (xchg_cnt == '0)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            swaps_q     <= '0;
            phase_q     <= '0;
            desc_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            swaps_q     <= swaps_d;
            phase_q     <= phase_d;
            desc_q      <= desc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SORTER_EARLY_EXIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_q <= 1'b0;
        end else begin
            quiet_q <= quiet_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = vec_q;
    assign bus.out_swaps = swaps_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_odd_even_sorter.sv
// Directed testbench for odd_even_sorter (N=8, W=8). Elements are written
// e7..e0 in the 64-bit literals (e0 is the least significant byte).
module tb_odd_even_sorter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    odd_even_sorter_if #(.N(8), .W(8), .SWAP_W(16)) bus ();

    odd_even_sorter #(.N(8), .W(8), .SWAP_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge while IDLE; returns at the negedge where out_valid
    // was first seen (lat = edges after the transfer edge), or after a timeout.
    task automatic sort_one(input logic [63:0] data, input logic desc,
                            output int lat, output int t_xfer);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_desc  = desc;
        @(posedge clk);
        @(negedge clk);
        t_xfer       = cyc;
        bus.in_valid = 1'b0;
        bus.in_desc  = ~desc;
        bus.in_data  = 64'h5A5A_5A5A_5A5A_5A5A;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== 64'h0 || bus.out_swaps !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_values: rdy=%b vld=%b busy=%b data=%h swaps=%0d required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.out_swaps);
        end
    endtask

    task automatic test_ascending();
        int lat, t;
        sort_one(64'h04_07_02_09_01_08_03_05, 1'b0, lat, t);
        n_cmp++;
        if (bus.out_data !== 64'h09_08_07_05_04_03_02_01) begin
            n_bad++; $display("FAIL asc_data: got %h required %h", bus.out_data, 64'h09_08_07_05_04_03_02_01);
        end
        n_cmp++;
        if (bus.out_swaps !== 16'd14) begin
            n_bad++; $display("FAIL asc_swaps: got %0d required 14", bus.out_swaps);
        end
`ifdef SORTER_EARLY_EXIT_EN
        n_cmp++;
        if (lat < 2 || lat > 8) begin
            n_bad++; $display("FAIL asc_latency: got %0d required 2..8", lat);
        end
`else
        n_cmp++;
        if (lat !== 8) begin
            n_bad++; $display("FAIL asc_latency: got %0d required 8", lat);
        end
`endif
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL asc_done_flags: busy=%b rdy=%b required 1 0", bus.busy, bus.in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 64'h09_08_07_05_04_03_02_01) begin
            n_bad++; $display("FAIL asc_after_handshake: vld=%b rdy=%b data=%h required 0 1 held",
                              bus.out_valid, bus.in_ready, bus.out_data);
        end
    endtask

    task automatic test_descending();
        int lat, t;
        sort_one(64'h04_07_02_09_01_08_03_05, 1'b1, lat, t);
        n_cmp++;
        if (bus.out_data !== 64'h01_02_03_04_05_07_08_09) begin
            n_bad++; $display("FAIL desc_data: got %h required %h", bus.out_data, 64'h01_02_03_04_05_07_08_09);
        end
        n_cmp++;
        if (bus.out_swaps !== 16'd14) begin
            n_bad++; $display("FAIL desc_swaps: got %0d required 14", bus.out_swaps);
        end
        @(negedge clk);
    endtask

    task automatic test_presorted();
        int lat, t;
        sort_one(64'h07_06_05_04_03_02_01_00, 1'b0, lat, t);
        n_cmp++;
        if (bus.out_data !== 64'h07_06_05_04_03_02_01_00 || bus.out_swaps !== 16'd0) begin
            n_bad++; $display("FAIL presorted: data=%h swaps=%0d required unchanged 0", bus.out_data, bus.out_swaps);
        end
`ifdef SORTER_EARLY_EXIT_EN
        n_cmp++;
        if (lat !== 2) begin
            n_bad++; $display("FAIL presorted_latency: got %0d required 2", lat);
        end
`else
        n_cmp++;
        if (lat !== 8) begin
            n_bad++; $display("FAIL presorted_latency: got %0d required 8", lat);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_duplicates();
        int lat, t;
        sort_one(64'h00_FF_00_FF_00_FF_00_FF, 1'b0, lat, t);
        n_cmp++;
        if (bus.out_data !== 64'hFF_FF_FF_FF_00_00_00_00 || bus.out_swaps !== 16'd10) begin
            n_bad++; $display("FAIL unsigned_dup: data=%h swaps=%0d required %h 10",
                              bus.out_data, bus.out_swaps, 64'hFF_FF_FF_FF_00_00_00_00);
        end
        @(negedge clk);
        sort_one(64'hAA_AA_AA_AA_AA_AA_AA_AA, 1'b0, lat, t);
        n_cmp++;
        if (bus.out_data !== 64'hAA_AA_AA_AA_AA_AA_AA_AA || bus.out_swaps !== 16'd0) begin
            n_bad++; $display("FAIL all_equal: data=%h swaps=%0d required all AA 0", bus.out_data, bus.out_swaps);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat, t;
        bus.out_ready = 1'b0;
        sort_one(64'h00_FF_00_FF_00_FF_00_FF, 1'b0, lat, t);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 64'h11_22_33_44_55_66_77_88;
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_data !== 64'hFF_FF_FF_FF_00_00_00_00 || bus.out_swaps !== 16'd10) begin
                n_bad++; $display("FAIL backpressure_hold[%0d]: vld=%b rdy=%b data=%h swaps=%0d required 1 0 stable",
                                  i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_swaps);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 64'hFF_FF_FF_FF_00_00_00_00) begin
            n_bad++; $display("FAIL backpressure_release: vld=%b rdy=%b data=%h required 0 1 old result",
                              bus.out_valid, bus.in_ready, bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        int lat0, lat1, t0, t1;
        sort_one(64'h00_01_02_03_04_05_06_07, 1'b0, lat0, t0);
        n_cmp++;
        if (bus.out_data !== 64'h07_06_05_04_03_02_01_00 || bus.out_swaps !== 16'd28) begin
            n_bad++; $display("FAIL b2b_first: data=%h swaps=%0d required %h 28",
                              bus.out_data, bus.out_swaps, 64'h07_06_05_04_03_02_01_00);
        end
        @(negedge clk);
        sort_one(64'h07_06_05_04_03_02_01_00, 1'b1, lat1, t1);
        n_cmp++;
        if (bus.out_data !== 64'h00_01_02_03_04_05_06_07 || bus.out_swaps !== 16'd28) begin
            n_bad++; $display("FAIL b2b_second: data=%h swaps=%0d required %h 28",
                              bus.out_data, bus.out_swaps, 64'h00_01_02_03_04_05_06_07);
        end
        n_cmp++;
        if (t1 - t0 !== 10) begin
            n_bad++; $display("FAIL b2b_interval: got %0d cycles required 10", t1 - t0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sort();
        int seen;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h04_07_02_09_01_08_03_05;
        bus.in_desc  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== 64'h0 || bus.out_swaps !== 16'h0) begin
            n_bad++; $display("FAIL reset_mid_sort: rdy=%b vld=%b busy=%b data=%h swaps=%0d required 1 0 0 0 0",
                              bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.out_swaps);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL reset_no_output: active cycles %0d required 0", seen);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_desc   = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_ascending();
        test_descending();
        test_presorted();
        test_duplicates();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_sort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
